sprite_attr_table: RTL
======================

// Module: sprite_attr_table
// PURPOSE
//  Parametrised, double-buffered sprite attribute store; successor to the 8x8 attribute register file.
//  CPU/loader writes a shadow bank by single write or auto-incrementing burst; Commit (vsync) copies
//  shadow -> active bank in one cycle. Active bank drives the sprite renderer, so no mid-frame tearing.
// PARAMETERS
//  NUM_ENTRIES  8                          number of sprite attribute entries (>=2, any integer)
//  DATA_W       8                          bits per entry
//  ADDR_W       $clog2(NUM_ENTRIES)        entry index width (derived, do not override)
// PORTS
//  Clk          in   1                     single clock, rising edge
//  Reset        in   1                     asynchronous, active-low; clears all state
//  Load         in   1                     single write strobe to shadow[Addr] (IDLE only)
//  Addr         in   ADDR_W                write index / burst start index
//  Data_in      in   DATA_W                single-write data
//  Burst_start  in   1                     start burst at Addr, length Burst_len (IDLE only)
//  Burst_len    in   ADDR_W+1              beats in burst; 0 = no-op; >NUM_ENTRIES clamped
//  Burst_valid  in   1                     burst beat valid
//  Burst_data   in   DATA_W                burst beat data
//  Burst_ready  out  1                     1 while in BURST
//  Burst_done   out  1                     1-cycle pulse the cycle after the last beat is accepted
//  Commit       in   1                     shadow->active copy request (pulse)
//  Busy         out  1                     1 in BURST or COMMIT_PEND
//  Dout         out  NUM_ENTRIES*DATA_W    active bank, entry i at [i*DATA_W +: DATA_W]
//  Parity_err   out  1                     only with SPRITE_ATTR_PARITY_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset: both banks 0, FSM IDLE, pointer/count 0, Burst_ready=0, Burst_done=0, Busy=0, Dout=0.
//  FSM IDLE -> BURST on Burst_start with Burst_len!=0; Burst_len==0 stays IDLE, no Burst_done.
//  IDLE: Load writes shadow[Addr] at clock edge; Addr>=NUM_ENTRIES write dropped silently.
//  BURST: beat accepted when Burst_valid & Burst_ready; writes shadow[ptr]; ptr wraps NUM_ENTRIES-1 -> 0.
//   After last beat: next cycle IDLE (or COMMIT_PEND), Burst_done=1 for exactly that cycle.
//   Load and Burst_start ignored in BURST and COMMIT_PEND (no queuing).
//  Commit in IDLE: active <= shadow incl. same-cycle Load write (write-first); Dout updates next cycle.
//  Commit in BURST: latched; FSM -> COMMIT_PEND after last beat; copy occurs on COMMIT_PEND cycle,
//   then IDLE. Multiple Commits while pending collapse to one.
//  Commit on same cycle as last beat: that beat is included in the copy.
//  Latency: single write -> Dout only after Commit; Commit(IDLE) -> Dout valid 1 cycle later.
//  Reset asserted mid-burst/mid-pend: immediate clear; partial burst and pending commit discarded.
// CONFIGURATION
//  `SPRITE_ATTR_PARITY_EN defined: each active entry stores an extra even-parity bit computed at
//   commit; checked continuously; any mismatch sets Parity_err (sticky, cleared only by Reset).
//  Not defined: no parity storage; Parity_err port present, tied to 0.
// STRUCTURE
//  Package sprite_attr_pkg: state enum {IDLE, BURST, COMMIT_PEND}, parity function,
//   clamp helper for Burst_len.
//  Sub-module attr_burst_ctrl: FSM, wrapping pointer, beat counter, commit-pending flag,
//   Burst_done generation; top holds both banks and Dout packing.
// TESTING
//  1 Load Addr=3 Data_in=8'hA5, no Commit -> Dout entry3=0; Commit -> next cycle entry3=8'hA5.
//  2 Burst Addr=6 len=4, data 11,22,33,44 with valid gaps -> shadow[6,7,0,1]; Burst_done pulse 1 cycle.
//  3 Commit mid-burst (beat 2 of 4) -> Busy=1, Dout unchanged until COMMIT_PEND; all 4 beats then visible.
//  4 Burst_len=0 -> stays IDLE, no Burst_ready/Burst_done; Burst_len=9 (N=8) -> exactly 8 beats.
//  5 Reset low during beat 3 -> all Dout=0, Busy=0, later Commit copies zeros.
//  6 PARITY_EN: force flip active entry bit -> Parity_err=1 and stays 1 until Reset; without macro = 0.

Source files
------------

// File: rtl/sprite_attr_pkg.sv
// rtl/sprite_attr_pkg.sv - shared types and helpers for the double-buffered sprite attribute table
package sprite_attr_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    BURST       = 2'd1,
    COMMIT_PEND = 2'd2
  } state_t;

  localparam int unsigned PARITY_MAX_W = 64;

  // Even parity: the stored bit makes the total count of ones even
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] d);
    return ^d;
  endfunction

  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned n);
    return (len > n) ? n : len;
  endfunction

endpackage

// File: rtl/attr_burst_ctrl.sv
// rtl/attr_burst_ctrl.sv - burst/commit sequencer: FSM, wrapping write pointer, beat count, pending commit
module attr_burst_ctrl
  import sprite_attr_pkg::*;
#(
  parameter int NUM_ENTRIES = 8,
  parameter int ADDR_W      = $clog2(NUM_ENTRIES)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Burst_start,
  input  logic [ADDR_W:0]   Burst_len,
  input  logic [ADDR_W-1:0] Addr,
  input  logic              Burst_valid,
  input  logic              Commit,
  output logic              Burst_ready,
  output logic              Burst_done,
  output logic              Busy,
  output logic              beat_en,
  output logic [ADDR_W-1:0] beat_ptr,
  output logic              copy_en
);

  state_t            state;
  logic [ADDR_W:0]   remain;
  logic [ADDR_W-1:0] ptr;
  logic              pend;
  logic [ADDR_W:0]   len_clamped;

  assign len_clamped = (ADDR_W+1)'(clamp_len(32'(Burst_len), NUM_ENTRIES));
  assign beat_en     = Burst_valid & Burst_ready;
  assign beat_ptr    = ptr;
  assign copy_en     = ((state == IDLE) & Commit) | (state == COMMIT_PEND);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      remain      <= '0;
      ptr         <= '0;
      pend        <= 1'b0;
      Burst_ready <= 1'b0;
      Burst_done  <= 1'b0;
      Busy        <= 1'b0;
    end else begin
      Burst_done <= 1'b0;
      case (state)
        IDLE: begin
          if (Burst_start && (Burst_len != '0)) begin
            state       <= BURST;
            ptr         <= Addr;
            remain      <= len_clamped;
            pend        <= 1'b0;
            Burst_ready <= 1'b1;
            Busy        <= 1'b1;
          end
        end
        BURST: begin
          if (Commit) pend <= 1'b1;
          if (beat_en) begin
            ptr    <= (ptr >= ADDR_W'(NUM_ENTRIES-1)) ? '0 : ptr + 1'b1;
            remain <= remain - 1'b1;
            if (remain == (ADDR_W+1)'(1)) begin
              // Commit arriving with the last beat still defers the copy so that beat is included
              Burst_done  <= 1'b1;
              Burst_ready <= 1'b0;
              pend        <= 1'b0;
              if (pend || Commit) begin
                state <= COMMIT_PEND;
              end else begin
                state <= IDLE;
                Busy  <= 1'b0;
              end
            end
          end
        end
        COMMIT_PEND: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          Burst_ready <= 1'b0;
          Busy        <= 1'b0;
          pend        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/sprite_attr_table.sv
// rtl/sprite_attr_table.sv - shadow/active sprite attribute banks; optional parity via SPRITE_ATTR_PARITY_EN
module sprite_attr_table
  import sprite_attr_pkg::*;
#(
  parameter int NUM_ENTRIES = 8,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = $clog2(NUM_ENTRIES)
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          Load,
  input  logic [ADDR_W-1:0]             Addr,
  input  logic [DATA_W-1:0]             Data_in,
  input  logic                          Burst_start,
  input  logic [ADDR_W:0]               Burst_len,
  input  logic                          Burst_valid,
  input  logic [DATA_W-1:0]             Burst_data,
  output logic                          Burst_ready,
  output logic                          Burst_done,
  input  logic                          Commit,
  output logic                          Busy,
  output logic [NUM_ENTRIES*DATA_W-1:0] Dout,
  output logic                          Parity_err
);

  logic [DATA_W-1:0] shadow     [NUM_ENTRIES];
  logic [DATA_W-1:0] shadow_nxt [NUM_ENTRIES];
  logic [DATA_W-1:0] active     [NUM_ENTRIES];
  logic              beat_en;
  logic [ADDR_W-1:0] beat_ptr;
  logic              copy_en;
  logic              addr_ok;
  logic              ptr_ok;

  attr_burst_ctrl #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .ADDR_W      (ADDR_W)
  ) u_ctrl (
    .Clk         (Clk),
    .Reset       (Reset),
    .Burst_start (Burst_start),
    .Burst_len   (Burst_len),
    .Addr        (Addr),
    .Burst_valid (Burst_valid),
    .Commit      (Commit),
    .Burst_ready (Burst_ready),
    .Burst_done  (Burst_done),
    .Busy        (Busy),
    .beat_en     (beat_en),
    .beat_ptr    (beat_ptr),
    .copy_en     (copy_en)
  );

  assign addr_ok = ({1'b0, Addr} < (ADDR_W+1)'(NUM_ENTRIES));
  assign ptr_ok  = ({1'b0, beat_ptr} < (ADDR_W+1)'(NUM_ENTRIES));

  // Commit copies from shadow_nxt so a same-cycle write lands in the active bank (write-first)
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) shadow_nxt[i] = shadow[i];
    if (Load && !Busy && addr_ok) shadow_nxt[Addr] = Data_in;
    if (beat_en && ptr_ok) shadow_nxt[beat_ptr] = Burst_data;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        shadow[i] <= shadow_nxt[i];
        if (copy_en) active[i] <= shadow_nxt[i];
      end
    end
  end

  always_comb begin
    Dout = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) Dout[i*DATA_W +: DATA_W] = active[i];
  end

`ifdef SPRITE_ATTR_PARITY_EN
  logic [NUM_ENTRIES-1:0] active_par;
  logic                   par_mismatch;

  always_comb begin
    par_mismatch = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++)
      par_mismatch = par_mismatch | (even_parity(PARITY_MAX_W'(active[i])) ^ active_par[i]);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      active_par <= '0;
      Parity_err <= 1'b0;
    end else begin
      if (copy_en)
        for (int i = 0; i < NUM_ENTRIES; i++)
          active_par[i] <= even_parity(PARITY_MAX_W'(shadow_nxt[i]));
      Parity_err <= Parity_err | par_mismatch;
    end
  end
`else
  assign Parity_err = 1'b0;
`endif

endmodule
